// File: rtl/asic_latch_ram_writer.sv
// Write-side controller for the latch RAM write port.
// Clears the whole RAM after reset or on request, then accepts byte-masked
// write requests and performs a read-modify-write through a single stage.
// The stage register doubles as the RAM output register: a request captured
// on one edge is presented to the RAM for the whole following cycle, and the
// byte merge uses the RAM's combinational read of that same address.
module asic_latch_ram_writer #(
   parameter int                  DATA_WIDTH  = 32,
   parameter int                  ADDR_WIDTH  = 5,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_data,
   input  logic [DATA_WIDTH/8-1:0] req_mask,
   input  logic                    clear_start,
   output logic                    clear_busy,
   output logic                    clear_done,
   output logic                    ram_write_enable,
   output logic [ADDR_WIDTH-1:0]   ram_write_addr,
   output logic [DATA_WIDTH-1:0]   ram_write_data_in,
   input  logic [DATA_WIDTH-1:0]   ram_write_data_out
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   sweep_addr, sweep_addr_n;
   logic                    sweep_last, sweep_last_n;
   logic                    stage_valid, stage_valid_n;
   logic [DATA_WIDTH-1:0]   stage_data, stage_data_n;
   logic [MASK_WIDTH-1:0]   stage_mask, stage_mask_n;
   logic                    wr_en, wr_en_n;
   logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_n;
   logic                    wr_merge, wr_merge_n;
   logic                    done_q, done_n;
   logic                    handshake;
   logic [DATA_WIDTH-1:0]   merged;

   assign req_ready         = (state == ST_RUN);
   assign clear_busy        = (state != ST_RUN);
   assign clear_done        = done_q;
   assign handshake         = req_valid && req_ready;
   assign ram_write_enable  = wr_en;
   assign ram_write_addr    = wr_addr;
   assign ram_write_data_in = wr_merge ? merged : CLEAR_VALUE;

   // Byte merge of the staged request over the current RAM word at the stage address.
   always_comb begin
      merged = ram_write_data_out;
      for (int i = 0; i < MASK_WIDTH; i++) begin
         if (stage_mask[i]) begin
            merged[i*8 +: 8] = stage_data[i*8 +: 8];
         end
      end
   end

   // Next-state and next-output logic for sweep, request capture and drain.
   always_comb begin
      state_n       = state;
      sweep_addr_n  = sweep_addr;
      sweep_last_n  = sweep_last;
      stage_valid_n = 1'b0;
      stage_data_n  = stage_data;
      stage_mask_n  = stage_mask;
      wr_en_n       = 1'b0;
      wr_addr_n     = wr_addr;
      wr_merge_n    = wr_merge;
      done_n        = 1'b0;
      case (state)
         ST_CLEAR: begin
            if (sweep_last) begin
               state_n = ST_RUN;
               done_n  = 1'b1;
            end else begin
               wr_en_n    = 1'b1;
               wr_addr_n  = sweep_addr;
               wr_merge_n = 1'b0;
               if (sweep_addr == LAST_ADDR) begin
                  sweep_last_n = 1'b1;
               end else begin
                  sweep_addr_n = sweep_addr + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (handshake) begin
               stage_valid_n = 1'b1;
               stage_data_n  = req_data;
               stage_mask_n  = req_mask;
               wr_en_n       = 1'b1;
               wr_addr_n     = req_addr;
               wr_merge_n    = 1'b1;
            end
            if (clear_start) begin
               if (stage_valid || handshake) begin
                  state_n = ST_DRAIN;
               end else begin
                  state_n      = ST_CLEAR;
                  sweep_addr_n = '0;
                  sweep_last_n = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            state_n      = ST_CLEAR;
            sweep_addr_n = '0;
            sweep_last_n = 1'b0;
         end
         default: begin
            state_n = ST_CLEAR;
         end
      endcase
   end

   // State and output registers; reset drops any staged request and rearms the sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_CLEAR;
         sweep_addr  <= '0;
         sweep_last  <= 1'b0;
         stage_valid <= 1'b0;
         stage_data  <= '0;
         stage_mask  <= '1;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_merge    <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state       <= state_n;
         sweep_addr  <= sweep_addr_n;
         sweep_last  <= sweep_last_n;
         stage_valid <= stage_valid_n;
         stage_data  <= stage_data_n;
         stage_mask  <= stage_mask_n;
         wr_en       <= wr_en_n;
         wr_addr     <= wr_addr_n;
         wr_merge    <= wr_merge_n;
         done_q      <= done_n;
      end
   end

endmodule

// File: tb/tb_asic_latch_ram_writer.sv
// Testbench for asic_latch_ram_writer with a behavioural latch RAM and a
// word-level reference memory updated at every accepted request.
module tb_asic_latch_ram_writer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_mask;
   logic        clear_start;
   logic        clear_busy;
   logic        clear_done;
   logic        ram_write_enable;
   logic [4:0]  ram_write_addr;
   logic [31:0] ram_write_data_in;
   logic [31:0] ram_write_data_out;

   logic [31:0] ram [32];
   logic [31:0] refMem [32];
   int          compared;
   int          mismatched;
   int          cycle;

   asic_latch_ram_writer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .CLEAR_VALUE(32'h0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_addr          (req_addr),
      .req_data          (req_data),
      .req_mask          (req_mask),
      .clear_start       (clear_start),
      .clear_busy        (clear_busy),
      .clear_done        (clear_done),
      .ram_write_enable  (ram_write_enable),
      .ram_write_addr    (ram_write_addr),
      .ram_write_data_in (ram_write_data_in),
      .ram_write_data_out(ram_write_data_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural RAM: combinational read, write on the rising edge; filled with junk while in reset.
   assign ram_write_data_out = ram[ram_write_addr];
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (ram_write_enable) begin
         ram[ram_write_addr] <= ram_write_data_in;
      end else if (!rst) begin
         for (int i = 0; i < 32; i++) ram[i] <= $urandom;
      end
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refWrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
      for (int b = 0; b < 4; b++) begin
         if (m[b]) refMem[a][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   // Present one request, wait (bounded) for ready, complete the handshake; valid is left high.
   task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
      int tries;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
      tries = 0;
      while (!req_ready && tries < 50) begin
         @(posedge clk);
         #1;
         tries++;
      end
      if (!req_ready) begin
         checkOutput("ready_timeout", 64'(req_ready), 64'd1);
      end else begin
         @(posedge clk);
         refWrite(a, d, m);
         #1;
      end
   endtask

   task automatic idleCycles(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Follow a full clear sweep until the controller returns to accepting requests.
   task automatic sweepCheck(input string tag);
      int  n;
      int  done;
      int  zeros;
      bit  fin;
      n = 0;
      done = 0;
      fin = 1'b0;
      for (int c = 0; c < 100 && !fin; c++) begin
         @(posedge clk);
         #1;
         if (ram_write_enable) begin
            checkOutput({tag, "_addr"}, 64'(ram_write_addr), 64'(n));
            checkOutput({tag, "_data"}, 64'(ram_write_data_in), 64'h0);
            n++;
         end
         if (clear_done) done++;
         if (!clear_busy) fin = 1'b1;
      end
      checkOutput({tag, "_finished"}, 64'(fin), 64'd1);
      checkOutput({tag, "_writes"}, 64'(n), 64'd32);
      checkOutput({tag, "_done_pulses"}, 64'(done), 64'd1);
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_drop"}, 64'(clear_done), 64'd0);
      zeros = 0;
      for (int i = 0; i < 32; i++) begin
         if (ram[i] === 32'h0) zeros++;
         refMem[i] = 32'h0;
      end
      checkOutput({tag, "_cleared"}, 64'(zeros), 64'd32);
   endtask

   // Directed sequence: reset, sweep, masked writes, streaming, clear, mid-sweep reset.
   initial begin
      int  c0;
      int  found;
      logic [31:0] d;
      logic [3:0]  m;
      compared    = 0;
      mismatched  = 0;
      cycle       = 0;
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_data    = '0;
      req_mask    = '0;
      clear_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_busy", 64'(clear_busy), 64'd1);
      checkOutput("rst_done", 64'(clear_done), 64'd0);
      checkOutput("rst_we", 64'(ram_write_enable), 64'd0);
      checkOutput("rst_addr", 64'(ram_write_addr), 64'd0);
      checkOutput("rst_data", 64'(ram_write_data_in), 64'd0);
      rst = 1'b1;
      sweepCheck("sweep1");

      applyStimulus(5'd1, 32'h42, 4'hF);
      checkOutput("lat_we", 64'(ram_write_enable), 64'd1);
      checkOutput("lat_addr", 64'(ram_write_addr), 64'd1);
      checkOutput("lat_data", 64'(ram_write_data_in), 64'h42);
      applyStimulus(5'd1, 32'hAABBCCDD, 4'b0010);
      idleCycles(2);
      checkOutput("merge_addr1", 64'(ram[1]), 64'h0000CC42);

      applyStimulus(5'd3, 32'h11111111, 4'b0001);
      applyStimulus(5'd3, 32'h22222222, 4'b1000);
      idleCycles(2);
      checkOutput("b2b_addr3", 64'(ram[3]), 64'h22000011);
      checkOutput("idle_we", 64'(ram_write_enable), 64'd0);

      c0 = cycle;
      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         if (i == 5) m = 4'h0;
         if (i == 6) m = 4'hF;
         applyStimulus(5'(i), d, m);
      end
      checkOutput("stream_cycles", 64'(cycle - c0), 64'd32);
      idleCycles(2);
      for (int i = 0; i < 32; i++) begin
         checkOutput($sformatf("stream_word%0d", i), 64'(ram[i]), 64'(refMem[i]));
      end

      d = $urandom;
      req_valid   = 1'b1;
      req_addr    = 5'd7;
      req_data    = d;
      req_mask    = 4'hF;
      clear_start = 1'b1;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      clear_start = 1'b0;
      checkOutput("drain_ready", 64'(req_ready), 64'd0);
      checkOutput("drain_we", 64'(ram_write_enable), 64'd1);
      checkOutput("drain_addr", 64'(ram_write_addr), 64'd7);
      @(posedge clk);
      #1;
      checkOutput("drain_word7", 64'(ram[7]), 64'(d));
      sweepCheck("sweep2");

      idleCycles(2);
      clear_start = 1'b1;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      found = 0;
      for (int c = 0; c < 50 && found == 0; c++) begin
         @(posedge clk);
         #1;
         if (ram_write_enable && ram_write_addr == 5'd10) found = 1;
      end
      checkOutput("reach_addr10", 64'(found), 64'd1);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_we", 64'(ram_write_enable), 64'd0);
      checkOutput("mid_rst_addr", 64'(ram_write_addr), 64'd0);
      checkOutput("mid_rst_busy", 64'(clear_busy), 64'd1);
      checkOutput("mid_rst_ready", 64'(req_ready), 64'd0);
      checkOutput("mid_rst_data", 64'(ram_write_data_in), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      sweepCheck("sweep3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
